mod_arith_unit: RTL and testbench

MOD_ARITH_UNIT -- requirements
Module: mod_arith_unit

---
 rtl/mod_arith_unit.sv | 175 +++++++++++++++++
 tb/tb_mod_arith_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_arith_unit.sv
// mod_arith_unit
//
// Modular arithmetic engine over a prime field GF(P). Performs one of four
// operations per request: ADD and SUB finish in a single execute cycle, MUL
// and SQR use an interleaved MSB-first double-and-add loop that takes WIDTH
// execute cycles. Every modular step keeps WIDTH+1-bit intermediates and
// applies at most one conditional subtraction of P, which is sufficient
// because every operand entering a step is already reduced below P.
//
// Ports
//   Clk      in   1      rising-edge clock
//   Reset_n  in   1      asynchronous active-low reset
//   start    in   1      operation request, sampled in IDLE or DONE
//   mode     in   2      00 ADD, 01 SUB, 10 MUL, 11 SQR
//   a        in   WIDTH  first operand (< P)
//   b        in   WIDTH  second operand (< P), ignored for SQR
//   result   out  WIDTH  reduced result, updated when an operation completes
//   busy     out  1      high while an operation executes
//   done     out  1      one-cycle pulse when result is valid

module mod_arith_unit #(
    parameter int               WIDTH = 256,
    parameter logic [WIDTH-1:0] P     = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_SQR = 2'b11;

    localparam logic [WIDTH:0] P_EXT = {1'b0, P};

    // P < 2^WIDTH holds by construction of the parameter type; the remaining
    // constraints must be rejected at elaboration.
    if (P[0] == 1'b0 || P <= 2) begin : g_bad_modulus
        $error("mod_arith_unit: modulus P must be odd and greater than 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]   sum_ext, add_full;
    logic [WIDTH:0]   diff_ext, diff_wrap;
    logic [WIDTH-1:0] add_res, sub_res;
    logic [WIDTH:0]   dbl_ext, dbl_red;
    logic [WIDTH:0]   step_sum, step_red;
    logic [WIDTH-1:0] step_res;
    logic             unused_top_bits;

    // ADD: the sum of two reduced operands is below 2P, so one conditional
    // subtraction brings it back into range.
    always_comb begin
        sum_ext  = {1'b0, a_q} + {1'b0, b_q};
        add_full = (sum_ext >= P_EXT) ? (sum_ext - P_EXT) : sum_ext;
        add_res  = add_full[WIDTH-1:0];
    end

    // SUB: a negative difference wraps modulo 2^(WIDTH+1); adding P restores
    // the correct residue in the low WIDTH bits.
    always_comb begin
        diff_ext  = {1'b0, a_q} - {1'b0, b_q};
        diff_wrap = diff_ext + P_EXT;
        sub_res   = (a_q >= b_q) ? diff_ext[WIDTH-1:0] : diff_wrap[WIDTH-1:0];
    end

    // One MUL/SQR iteration: double the accumulator mod P, then add a mod P
    // when the current multiplier bit is set.
    always_comb begin
        dbl_ext  = {acc_q, 1'b0};
        dbl_red  = (dbl_ext >= P_EXT) ? (dbl_ext - P_EXT) : dbl_ext;
        step_sum = {1'b0, dbl_red[WIDTH-1:0]} + {1'b0, a_q};
        step_red = (step_sum >= P_EXT) ? (step_sum - P_EXT) : step_sum;
        step_res = b_q[cnt_q] ? step_red[WIDTH-1:0] : dbl_red[WIDTH-1:0];
    end

    // The top bits of the reduced values are always zero for in-range
    // operands and are intentionally dropped.
    assign unused_top_bits = &{1'b0, add_full[WIDTH], diff_wrap[WIDTH],
                               dbl_red[WIDTH], step_red[WIDTH]};

    // Next-state logic: a request is accepted from IDLE or DONE (allowing
    // back-to-back operations); EXEC ignores start and runs to completion.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = (mode == MODE_SQR) ? a : b;
                    mode_d  = mode;
                    cnt_d   = CW'(WIDTH - 1);
                    acc_d   = '0;
                    state_d = EXEC;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                case (mode_q)
                    MODE_ADD: begin
                        result_d = add_res;
                        state_d  = DONE;
                    end
                    MODE_SUB: begin
                        result_d = sub_res;
                        state_d  = DONE;
                    end
                    default: begin
                        acc_d = step_res;
                        if (cnt_q == '0) begin
                            result_d = step_res;
                            state_d  = DONE;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == EXEC);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_mod_arith_unit.sv
// Testbench for mod_arith_unit: an 8-bit instance (P=251) exercises the
// functional table, random operations, back-to-back requests and reset
// abort; a default 256-bit instance checks wide multiplications.
module tb_mod_arith_unit;

    localparam logic [255:0] P256 = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] P8   = 256'd251;
    localparam logic [255:0] GX   = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic         Reset_n;
    logic         start8, busy8, done8;
    logic [1:0]   mode8;
    logic [7:0]   a8, b8, result8;
    logic         start256, busy256, done256;
    logic [1:0]   mode256;
    logic [255:0] a256, b256, result256;

    int vectors     = 0;
    int miscompares = 0;

    mod_arith_unit #(.WIDTH(8), .P(8'd251)) dut8 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start8), .mode(mode8),
        .a(a8), .b(b8), .result(result8), .busy(busy8), .done(done8)
    );

    mod_arith_unit dut256 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start256), .mode(mode256),
        .a(a256), .b(b256), .result(result256), .busy(busy256), .done(done256)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expected;
        string      name;
    } vec_t;

    vec_t table8[12];

    // Reference: plain modular arithmetic on 512-bit integers
    function automatic logic [255:0] modelRef(input logic [1:0] m, input logic [255:0] x,
                                              input logic [255:0] y, input logic [255:0] p);
        logic [511:0] xe, ye, pe, r;
        xe = {256'b0, x};
        ye = {256'b0, y};
        pe = {256'b0, p};
        case (m)
            2'b00:   r = (xe + ye) % pe;
            2'b01:   r = (xe + pe - ye) % pe;
            2'b10:   r = (xe * ye) % pe;
            default: r = (xe * xe) % pe;
        endcase
        return r[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        if (v >= P256) v = v - P256;
        return v;
    endfunction

    function automatic logic curBusy(input bit big);
        return big ? busy256 : busy8;
    endfunction

    function automatic logic curDone(input bit big);
        return big ? done256 : done8;
    endfunction

    function automatic logic [255:0] curResult(input bit big);
        return big ? result256 : {248'b0, result8};
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation, scramble the inputs during EXEC, and check
    // latency, result, busy duration and the single-cycle done pulse.
    task automatic applyStimulus(input bit big, input logic [1:0] m, input logic [255:0] av,
                                 input logic [255:0] bv, input logic [255:0] expRes,
                                 input string name);
        int expLat, lat, busyCycles;
        bit seen;
        expLat = m[1] ? (big ? 257 : 9) : 2;
        @(negedge Clk);
        if (big) begin
            start256 = 1'b1; mode256 = m; a256 = av; b256 = bv;
        end else begin
            start8 = 1'b1; mode8 = m; a8 = av[7:0]; b8 = bv[7:0];
        end
        lat = 0;
        seen = 1'b0;
        busyCycles = 0;
        for (int k = 1; k <= 300 && !seen; k++) begin
            @(posedge Clk);
            #1;
            if (k == 1) begin
                start8 = 1'b0; start256 = 1'b0;
                mode8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
                mode256 = 2'($urandom); a256 = rand256(); b256 = rand256();
            end
            if (curBusy(big)) busyCycles++;
            if (curDone(big)) begin
                seen = 1'b1;
                lat = k;
            end
        end
        checkOutput({name, " latency"}, lat, expLat);
        checkOutput({name, " result"}, curResult(big), expRes);
        checkOutput({name, " busy cycles"}, busyCycles, expLat - 1);
        @(posedge Clk);
        #1;
        checkOutput({name, " done pulse width"}, curDone(big), 0);
    endtask

    initial begin
        int doneCount;
        logic [1:0] m;
        logic [255:0] av, bv;

        Reset_n = 1'b0;
        start8 = 1'b0; mode8 = '0; a8 = '0; b8 = '0;
        start256 = 1'b0; mode256 = '0; a256 = '0; b256 = '0;

        table8[0]  = '{2'b00, 8'd250, 8'd3,   8'd2,   "add 250+3"};
        table8[1]  = '{2'b01, 8'd3,   8'd5,   8'd249, "sub 3-5"};
        table8[2]  = '{2'b01, 8'd7,   8'd7,   8'd0,   "sub 7-7"};
        table8[3]  = '{2'b10, 8'd200, 8'd200, 8'd91,  "mul 200*200"};
        table8[4]  = '{2'b11, 8'd17,  8'd99,  8'd38,  "sqr 17"};
        table8[5]  = '{2'b10, 8'd250, 8'd250, 8'd1,   "mul 250*250"};
        table8[6]  = '{2'b00, 8'd250, 8'd250, 8'd249, "add 250+250"};
        table8[7]  = '{2'b01, 8'd0,   8'd250, 8'd1,   "sub 0-250"};
        table8[8]  = '{2'b10, 8'd0,   8'd250, 8'd0,   "mul 0*250"};
        table8[9]  = '{2'b11, 8'd250, 8'd7,   8'd1,   "sqr 250"};
        table8[10] = '{2'b00, 8'd0,   8'd0,   8'd0,   "add 0+0"};
        table8[11] = '{2'b10, 8'd1,   8'd250, 8'd250, "mul 1*250"};

        repeat (2) @(negedge Clk);
        checkOutput("reset result8", result8, 0);
        checkOutput("reset busy8", busy8, 0);
        checkOutput("reset done8", done8, 0);
        checkOutput("reset result256", result256, 0);
        checkOutput("reset busy256", busy256, 0);
        checkOutput("reset done256", done256, 0);
        Reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, table8[i].mode, {248'b0, table8[i].a}, {248'b0, table8[i].b},
                          {248'b0, table8[i].expected}, table8[i].name);
        end

        for (int i = 0; i < 40; i++) begin
            m  = 2'($urandom_range(0, 3));
            av = 256'($urandom_range(0, 250));
            bv = 256'($urandom_range(0, 250));
            applyStimulus(1'b0, m, av, bv, modelRef(m, av, bv, P8), $sformatf("rand8 #%0d", i));
        end

        // Back-to-back with start held high: ADD 1+1, SUB 0-1, MUL 2*3
        @(negedge Clk);
        start8 = 1'b1; mode8 = 2'b00; a8 = 8'd1; b8 = 8'd1;
        doneCount = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge Clk);
            #1;
            checkOutput($sformatf("b2b done edge %0d", k), done8,
                        (k == 2 || k == 4 || k == 13) ? 1 : 0);
            checkOutput($sformatf("b2b busy edge %0d", k), busy8,
                        (k == 1 || k == 3 || (k >= 5 && k <= 12)) ? 1 : 0);
            if (done8) doneCount++;
            if (k == 2)  checkOutput("b2b add result", result8, 2);
            if (k == 4)  checkOutput("b2b sub result", result8, 250);
            if (k == 13) checkOutput("b2b mul result", result8, 6);
            if (k == 1) begin
                mode8 = 2'b01; a8 = 8'd0; b8 = 8'd1;
            end else if (k == 3) begin
                mode8 = 2'b10; a8 = 8'd2; b8 = 8'd3;
            end else if (k >= 5 && k <= 11) begin
                start8 = 1'($urandom); mode8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            end else if (k == 12) begin
                start8 = 1'b0;
            end
        end
        checkOutput("b2b done pulse count", doneCount, 3);

        // Reset asserted four edges into a MUL
        @(negedge Clk);
        start8 = 1'b1; mode8 = 2'b10; a8 = 8'd200; b8 = 8'd200;
        @(posedge Clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        checkOutput("abort result", result8, 0);
        checkOutput("abort busy", busy8, 0);
        checkOutput("abort done", done8, 0);
        start8 = 1'b1; mode8 = 2'b00; a8 = 8'd1; b8 = 8'd1;
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("start during reset busy", busy8, 0);
        checkOutput("start during reset done", done8, 0);
        @(negedge Clk);
        start8 = 1'b0;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        checkOutput("after release busy", busy8, 0);
        checkOutput("after release result", result8, 0);
        applyStimulus(1'b0, 2'b00, 256'd10, 256'd20, 256'd30, "post-reset add");

        // Default 256-bit instance
        applyStimulus(1'b1, 2'b10, GX, 256'd1, GX, "wide mul Gx*1");
        applyStimulus(1'b1, 2'b10, GX, 256'd0, 256'd0, "wide mul Gx*0");
        for (int i = 0; i < 4; i++) begin
            m  = 2'(i);
            av = rand256();
            bv = rand256();
            applyStimulus(1'b1, m, av, bv, modelRef(m, av, bv, P256), $sformatf("rand256 #%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
